trafficlight_nway: RTL

Parametrised N-approach intersection controller, the successor to the fixed two-direction (NS/EW) `trafficlight` block. It serves `N_APPR` approaches round-robin, each through a left-turn, green, yellow and all-red clearance phase with parametrised durations. It skips approaches with no demand and pre-empts to all-red on `emergency`. It sits directly behind the lamp drivers and exposes its current approach and phase for supervision logic and benches.

---
 rtl/trafficlight_nway_pkg.sv | 33 +++
 rtl/trafficlight_nway_if.sv | 35 +++
 rtl/trafficlight_nway_phase_timer.sv | 36 +++
 rtl/trafficlight_nway.sv | 193 +++++++++++++++++++
 4 files changed

// File: rtl/trafficlight_nway_pkg.sv
// Shared types and constants for the N-approach intersection controller.
//   phase_t : controller state encoding, also exported on the phase output
//   T_*_DEF : default phase durations in clock cycles
//   clog2   : ceiling log2, used for index and counter widths
package trafficlight_pkg;

    typedef enum logic [2:0] {
        ALLRED = 3'd0,
        LEFT   = 3'd1,
        GREEN  = 3'd2,
        YELLOW = 3'd3,
        EMERG  = 3'd4
    } phase_t;

    localparam int unsigned N_APPR_DEF   = 4;
    localparam int unsigned T_LEFT_DEF   = 3;
    localparam int unsigned T_GREEN_DEF  = 8;
    localparam int unsigned T_YELLOW_DEF = 3;
    localparam int unsigned T_ALLRED_DEF = 2;

    // Smallest r with 2**r >= v.
    function automatic int unsigned clog2(input int unsigned v);
        int unsigned r;
        r = 0;
        for (int unsigned i = 0; i < 32; i++) begin
            if ((64'd1 << i) < 64'(v)) begin
                r = i + 1;
            end
        end
        return r;
    endfunction

endpackage

// File: rtl/trafficlight_nway_if.sv
// Lamp/supervision bundle between the controller and the lamp drivers.
//   emergency   : pre-emption request (to controller)
//   demand      : per-approach vehicle-present flags (to controller)
//   LeftTurn, Green, Yellow, Red : per-approach lamps (from controller)
//   active      : approach index being served (from controller)
//   phase       : current phase_t encoding (from controller)
//   emer_active : high while pre-empted (from controller)
interface trafficlight_nway_if #(
    parameter int unsigned N_APPR = 4
) ();
    localparam int unsigned AW = trafficlight_pkg::clog2(N_APPR);

    logic              emergency;
    logic [N_APPR-1:0] demand;
    logic [N_APPR-1:0] LeftTurn;
    logic [N_APPR-1:0] Green;
    logic [N_APPR-1:0] Yellow;
    logic [N_APPR-1:0] Red;
    logic [AW-1:0]     active;
    logic [2:0]        phase;
    logic              emer_active;

    // Controller side.
    modport master (
        input  emergency, demand,
        output LeftTurn, Green, Yellow, Red, active, phase, emer_active
    );

    // Lamp driver / supervisor side.
    modport slave (
        output emergency, demand,
        input  LeftTurn, Green, Yellow, Red, active, phase, emer_active
    );

endinterface

// File: rtl/trafficlight_nway_phase_timer.sv
// Loadable down-counter timing one phase.
//   clk, rst : clock, async active-high reset (counter resets to RST_VALUE)
//   load     : reload the counter with value
//   value    : cycles-minus-one for the phase being entered
//   done     : registered flag, high while the counter reads 0
module phase_timer #(
    parameter int unsigned TW        = 4,
    parameter int unsigned RST_VALUE = 0
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          load,
    input  logic [TW-1:0] value,
    output logic          done
);

    logic [TW-1:0] r_cnt;
    logic          r_done;

    // Count down to zero and stop; done tracks the value the counter holds.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_cnt  <= TW'(RST_VALUE);
            r_done <= (RST_VALUE == 0);
        end else if (load) begin
            r_cnt  <= value;
            r_done <= (value == '0);
        end else if (r_cnt != '0) begin
            r_cnt  <= r_cnt - TW'(1);
            r_done <= (r_cnt == TW'(1));
        end
    end

    assign done = r_done;

endmodule

// File: rtl/trafficlight_nway.sv
// N-approach round-robin intersection controller with emergency pre-emption.
//   clk, rst : clock, async active-high reset
//   bus      : trafficlight_nway_if.master -- demand/emergency in, lamps,
//              active approach, phase and emer_active out (all registered)
module trafficlight_nway
    import trafficlight_pkg::*;
#(
    parameter int unsigned N_APPR   = N_APPR_DEF,
    parameter int unsigned T_LEFT   = T_LEFT_DEF,
    parameter int unsigned T_GREEN  = T_GREEN_DEF,
    parameter int unsigned T_YELLOW = T_YELLOW_DEF,
    parameter int unsigned T_ALLRED = T_ALLRED_DEF
) (
    input  logic                 clk,
    input  logic                 rst,
    trafficlight_nway_if.master  bus
);

    localparam int unsigned AW      = clog2(N_APPR);
    localparam int unsigned TMAX_LG = (T_LEFT > T_GREEN) ? T_LEFT : T_GREEN;
    localparam int unsigned TMAX_YA = (T_YELLOW > T_ALLRED) ? T_YELLOW : T_ALLRED;
    localparam int unsigned TMAX    = (TMAX_LG > TMAX_YA) ? TMAX_LG : TMAX_YA;
    localparam int unsigned TW      = clog2(TMAX + 1);
    localparam bit          HAS_LEFT  = (T_LEFT > 0);
    localparam int unsigned LD_LEFT   = HAS_LEFT ? T_LEFT - 1 : 0;
    localparam int unsigned LD_GREEN  = T_GREEN - 1;
    localparam int unsigned LD_YELLOW = T_YELLOW - 1;
    localparam int unsigned LD_ALLRED = T_ALLRED - 1;

    phase_t            r_state;
    phase_t            w_state_nxt;
    logic [AW-1:0]     r_active;
    logic [AW-1:0]     w_active_nxt;
    logic [AW-1:0]     w_sel;
    logic [AW-1:0]     w_idx;
    logic              w_found;
    logic              r_emer_pend;
    logic              w_pend_nxt;
    logic              w_load;
    logic [TW-1:0]     w_value;
    logic              w_done;
    logic [N_APPR-1:0] r_left, r_green, r_yellow, r_red;
    logic [N_APPR-1:0] w_left, w_green, w_yellow, w_red;
    logic              r_emer;

    phase_timer #(
        .TW        (TW),
        .RST_VALUE (LD_ALLRED)
    ) u_timer (
        .clk   (clk),
        .rst   (rst),
        .load  (w_load),
        .value (w_value),
        .done  (w_done)
    );

    // Round-robin: first requester after active, wrapping back to active
    // itself last; with no requester at all, simply step to active+1.
    always_comb begin
        w_sel   = (r_active == AW'(N_APPR - 1)) ? '0 : r_active + AW'(1);
        w_found = 1'b0;
        w_idx   = '0;
        for (int unsigned k = 1; k <= N_APPR; k++) begin
            w_idx = AW'((32'(r_active) + k) % N_APPR);
            if (!w_found && bus.demand[w_idx]) begin
                w_sel   = w_idx;
                w_found = 1'b1;
            end
        end
    end

    // Next state. Emergency is checked ahead of timer expiry everywhere;
    // a request seen during LEFT/GREEN/YELLOW is remembered so the yellow
    // phase can finish before entering EMERG.
    always_comb begin
        w_state_nxt  = r_state;
        w_active_nxt = r_active;
        w_pend_nxt   = r_emer_pend;
        w_load       = 1'b0;
        w_value      = '0;
        case (r_state)
            ALLRED: begin
                if (bus.emergency) begin
                    w_state_nxt = EMERG;
                    w_load      = 1'b1;
                end else if (w_done) begin
                    w_active_nxt = w_sel;
                    w_load       = 1'b1;
                    if (HAS_LEFT) begin
                        w_state_nxt = LEFT;
                        w_value     = TW'(LD_LEFT);
                    end else begin
                        w_state_nxt = GREEN;
                        w_value     = TW'(LD_GREEN);
                    end
                end
            end
            LEFT, GREEN: begin
                if (bus.emergency) begin
                    w_state_nxt = YELLOW;
                    w_pend_nxt  = 1'b1;
                    w_load      = 1'b1;
                    w_value     = TW'(LD_YELLOW);
                end else if (w_done) begin
                    w_state_nxt = (r_state == LEFT) ? GREEN : YELLOW;
                    w_load      = 1'b1;
                    w_value     = (r_state == LEFT) ? TW'(LD_GREEN) : TW'(LD_YELLOW);
                end
            end
            YELLOW: begin
                if (bus.emergency) begin
                    w_pend_nxt = 1'b1;
                end
                if (w_done) begin
                    w_load = 1'b1;
                    if (bus.emergency || r_emer_pend) begin
                        w_state_nxt = EMERG;
                        w_pend_nxt  = 1'b0;
                    end else begin
                        w_state_nxt = ALLRED;
                        w_value     = TW'(LD_ALLRED);
                    end
                end
            end
            EMERG: begin
                w_pend_nxt = 1'b0;
                if (!bus.emergency) begin
                    w_state_nxt = ALLRED;
                    w_load      = 1'b1;
                    w_value     = TW'(LD_ALLRED);
                end
            end
            default: begin
                w_state_nxt = ALLRED;
                w_pend_nxt  = 1'b0;
                w_load      = 1'b1;
                w_value     = TW'(LD_ALLRED);
            end
        endcase
    end

    // Lamp decode of the next state; the left arrow keeps its red lamp lit.
    always_comb begin
        w_left   = '0;
        w_green  = '0;
        w_yellow = '0;
        w_red    = '1;
        case (w_state_nxt)
            LEFT:   w_left[w_active_nxt] = 1'b1;
            GREEN: begin
                w_green[w_active_nxt] = 1'b1;
                w_red[w_active_nxt]   = 1'b0;
            end
            YELLOW: begin
                w_yellow[w_active_nxt] = 1'b1;
                w_red[w_active_nxt]    = 1'b0;
            end
            default: ;
        endcase
    end

    // State register and registered outputs.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state     <= ALLRED;
            r_active    <= AW'(N_APPR - 1);
            r_emer_pend <= 1'b0;
            r_left      <= '0;
            r_green     <= '0;
            r_yellow    <= '0;
            r_red       <= '1;
            r_emer      <= 1'b0;
        end else begin
            r_state     <= w_state_nxt;
            r_active    <= w_active_nxt;
            r_emer_pend <= w_pend_nxt;
            r_left      <= w_left;
            r_green     <= w_green;
            r_yellow    <= w_yellow;
            r_red       <= w_red;
            r_emer      <= (w_state_nxt == EMERG);
        end
    end

    assign bus.LeftTurn    = r_left;
    assign bus.Green       = r_green;
    assign bus.Yellow      = r_yellow;
    assign bus.Red         = r_red;
    assign bus.active      = r_active;
    assign bus.phase       = r_state;
    assign bus.emer_active = r_emer;

endmodule
